shift_arbiter_8: RTL and testbench
==================================

SHIFT_ARBITER_8 -- requirements
Module: shift_arbiter_8

Interface
REQ-001 Parameter SHIFT_ARB_TAG_W, default 4: width of each requester's opaque tag, which is returned unchanged with its result.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous reset, active-low.
REQ-004 a_valid / b_valid  input  1  requester A/B has a shift request pending.
REQ-005 a_ready / b_ready  output  1  request from A/B accepted this cycle.
REQ-006 a_data / b_data  input  8  operand.
REQ-007 a_amt / b_amt  input  3  shift amount, 0..7.
REQ-008 a_right / b_right  input  1  1 = shift right, 0 = shift left.
REQ-009 a_rot / b_rot  input  1  rotate instead of shift; used only when SHIFT_ARB_ROTATE_EN is defined.
REQ-010 a_tag / b_tag  input  SHIFT_ARB_TAG_W  requester tag.
REQ-011 rsp_valid  output  1  result register holds a valid result.
REQ-012 rsp_ready  input  1  consumer accepts the result this cycle.
REQ-013 rsp_data  output  8  shifted result.
REQ-014 rsp_src  output  1  source of the result: 0 = A, 1 = B.
REQ-015 rsp_tag  output  SHIFT_ARB_TAG_W  tag of the granted request.
REQ-016 grant_cnt_a / grant_cnt_b  output  16  wrapping count of accepted requests per requester.

Function
REQ-017 A request transfers when x_valid && x_ready; a response transfers when rsp_valid && rsp_ready.
REQ-018 The block has two states. EMPTY: no result held. FULL: result held.
REQ-019 can_accept = (state == EMPTY) || rsp_ready.
REQ-020 At most one of a_ready/b_ready is high in any cycle. Neither is high when can_accept is 0.
REQ-021 Arbitration is round-robin, using a 1-bit priority pointer.
  - Only one requester valid: that requester is granted.
  - Both valid: the requester named by the pointer is granted.
REQ-022 After every accepted request, the pointer moves to the requester that was not granted. Otherwise the pointer holds.
REQ-023 x_ready may depend combinationally on x_valid, on the other requester's valid, and on rsp_ready. No valid may depend on any ready.
REQ-024 Shift semantics:
  - right: out = data >> amt, zero-filled.
  - left: out = data << amt, zero-filled.
  - amt = 0: out = data.
REQ-025 Latency is exactly 1 cycle: a request accepted at edge t gives rsp_valid = 1 with its result after edge t.
REQ-026 rsp_data, rsp_src and rsp_tag are registered. They stay stable while rsp_valid && !rsp_ready.
REQ-027 State transitions:
  - EMPTY + accept -> FULL.
  - FULL + rsp_ready + accept -> FULL, loaded with the new result.
  - FULL + rsp_ready + no accept -> EMPTY.
  - FULL + !rsp_ready -> FULL, unchanged.
REQ-028 The granted requester's grant_cnt increments by 1 on each accepted request and wraps from 0xFFFF to 0x0000.
REQ-029 A requester that keeps valid high while back-pressured is never starved: under continuous contention, grants strictly alternate.

Reset
REQ-030 While rst_n is low:
  - state = EMPTY, rsp_valid = 0.
  - rsp_data = 0, rsp_src = 0, rsp_tag = 0.
  - pointer = A.
  - both grant counters = 0.
  - a_ready = b_ready = 0.
REQ-031 Reset asserted mid-operation discards any held result without a response handshake. The first accept after deassertion follows REQ-021 with the pointer at A.

Configuration
REQ-032 Macro SHIFT_ARB_ROTATE_EN:
  - Defined: when x_rot = 1, the shift is replaced by a rotate in the x_right direction by x_amt, with no zero-fill.
  - Undefined: x_rot is ignored and the behaviour is exactly REQ-024.
  - The port list is identical in both builds.

Structure
REQ-033 Package shift_arb_pkg holds:
  - constants DATA_W = 8 and AMT_W = 3;
  - the state enum {EMPTY, FULL};
  - the source encoding {SRC_A = 0, SRC_B = 1}.
REQ-034 The 8-bit shift/rotate datapath is one combinational sub-module, shift_arb_core_8. It is instantiated once and shared through the grant multiplexer.

Verification
REQ-035 Single-requester shifts:
  - A: data 0xB5, amt 3, right -> 0x16.
  - A: data 0xB5, amt 3, left -> 0xA8.
  - Each result appears one cycle after acceptance.
REQ-036 Contention with rsp_ready held 1:
  - A and B valid at every cycle after reset.
  - Grants go A, B, A, B.
  - grant_cnt_a = grant_cnt_b = 2 after 4 accepts.
REQ-037 Backpressure:
  - rsp_ready = 0 for 5 cycles while FULL -> rsp_data/src/tag stable, a_ready = b_ready = 0.
  - rsp_ready then rises -> a same-cycle drain+accept keeps rsp_valid = 1 with the new result.
REQ-038 Reset mid-operation: rst_n low while FULL -> rsp_valid = 0 immediately (asynchronous), counters = 0, next contended grant goes to A.
REQ-039 With SHIFT_ARB_ROTATE_EN defined: data 0x81, amt 1, right, rot = 1 -> 0xC0. The same stimulus without the macro -> 0x40.
REQ-040 Counter wrap: force 65536 A accepts -> grant_cnt_a returns to 0x0000, grant_cnt_b unchanged.

Source files
------------

// File: rtl/shift_arb_pkg.sv
//------------------------------------------------------------------------------
// shift_arb_pkg : shared widths, state and source encodings for shift_arbiter_8
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package shift_arb_pkg;
  localparam int DATA_W = 8;
  localparam int AMT_W  = 3;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_e;
endpackage

`default_nettype wire

// File: rtl/shift_arb_core_8.sv
//------------------------------------------------------------------------------
// shift_arb_core_8 : combinational 8-bit shifter; rotate option under SHIFT_ARB_ROTATE_EN
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module shift_arb_core_8
  import shift_arb_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  input  logic [AMT_W-1:0]  amt,
  input  logic              right,
  input  logic              rot,
  output logic [DATA_W-1:0] result
);

`ifdef SHIFT_ARB_ROTATE_EN
  logic [2*DATA_W-1:0] dbl_r;
  logic [2*DATA_W-1:0] dbl_l;

  // Shifting a doubled copy yields the rotation in one half without width games.
  always_comb begin
    dbl_r = {data, data} >> amt;
    dbl_l = {data, data} << amt;
    if (rot) begin
      result = right ? dbl_r[DATA_W-1:0] : dbl_l[2*DATA_W-1:DATA_W];
    end else begin
      result = right ? (data >> amt) : (data << amt);
    end
  end
`else
  logic unused_rot;
  assign unused_rot = rot;

  always_comb begin
    result = right ? (data >> amt) : (data << amt);
  end
`endif

endmodule

`default_nettype wire

// File: rtl/shift_arbiter_8.sv
//------------------------------------------------------------------------------
// shift_arbiter_8 : two-requester round-robin arbiter in front of one shared
// shifter, 1-deep registered result. Optional rotate via SHIFT_ARB_ROTATE_EN.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module shift_arbiter_8
  import shift_arb_pkg::*;
#(
  parameter int SHIFT_ARB_TAG_W = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       a_valid,
  output logic                       a_ready,
  input  logic [DATA_W-1:0]          a_data,
  input  logic [AMT_W-1:0]           a_amt,
  input  logic                       a_right,
  input  logic                       a_rot,
  input  logic [SHIFT_ARB_TAG_W-1:0] a_tag,
  input  logic                       b_valid,
  output logic                       b_ready,
  input  logic [DATA_W-1:0]          b_data,
  input  logic [AMT_W-1:0]           b_amt,
  input  logic                       b_right,
  input  logic                       b_rot,
  input  logic [SHIFT_ARB_TAG_W-1:0] b_tag,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_W-1:0]          rsp_data,
  output logic                       rsp_src,
  output logic [SHIFT_ARB_TAG_W-1:0] rsp_tag,
  output logic [15:0]                grant_cnt_a,
  output logic [15:0]                grant_cnt_b
);

  state_e                     state_q, state_d;
  src_e                       ptr_q, ptr_d;
  logic [DATA_W-1:0]          rsp_data_q, rsp_data_d;
  src_e                       rsp_src_q, rsp_src_d;
  logic [SHIFT_ARB_TAG_W-1:0] rsp_tag_q, rsp_tag_d;
  logic [15:0]                cnt_a_q, cnt_a_d;
  logic [15:0]                cnt_b_q, cnt_b_d;

  logic              can_accept;
  logic              grant_a;
  logic              grant_b;
  logic              accept;
  logic [DATA_W-1:0] op_data;
  logic [AMT_W-1:0]  op_amt;
  logic              op_right;
  logic              op_rot;
  logic [DATA_W-1:0] core_out;

  // rst_n gates the readies so nothing handshakes while reset is held.
  always_comb begin
    can_accept = rst_n && ((state_q == EMPTY) || rsp_ready);
    grant_a    = can_accept && a_valid && (!b_valid || (ptr_q == SRC_A));
    grant_b    = can_accept && b_valid && (!a_valid || (ptr_q == SRC_B));
    accept     = grant_a || grant_b;
    op_data    = grant_b ? b_data  : a_data;
    op_amt     = grant_b ? b_amt   : a_amt;
    op_right   = grant_b ? b_right : a_right;
    op_rot     = grant_b ? b_rot   : a_rot;
  end

  shift_arb_core_8 u_core (
    .data   (op_data),
    .amt    (op_amt),
    .right  (op_right),
    .rot    (op_rot),
    .result (core_out)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    rsp_data_d = rsp_data_q;
    rsp_src_d  = rsp_src_q;
    rsp_tag_d  = rsp_tag_q;
    cnt_a_d    = cnt_a_q;
    cnt_b_d    = cnt_b_q;

    if (accept) begin
      state_d    = FULL;
      rsp_data_d = core_out;
      rsp_src_d  = grant_b ? SRC_B : SRC_A;
      rsp_tag_d  = grant_b ? b_tag : a_tag;
      ptr_d      = grant_b ? SRC_A : SRC_B;
    end else if ((state_q == FULL) && rsp_ready) begin
      state_d = EMPTY;
    end

    if (grant_a) cnt_a_d = cnt_a_q + 16'd1;
    if (grant_b) cnt_b_d = cnt_b_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      ptr_q      <= SRC_A;
      rsp_data_q <= '0;
      rsp_src_q  <= SRC_A;
      rsp_tag_q  <= '0;
      cnt_a_q    <= '0;
      cnt_b_q    <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rsp_data_q <= rsp_data_d;
      rsp_src_q  <= rsp_src_d;
      rsp_tag_q  <= rsp_tag_d;
      cnt_a_q    <= cnt_a_d;
      cnt_b_q    <= cnt_b_d;
    end
  end

  assign a_ready     = grant_a;
  assign b_ready     = grant_b;
  assign rsp_valid   = (state_q == FULL);
  assign rsp_data    = rsp_data_q;
  assign rsp_src     = rsp_src_q;
  assign rsp_tag     = rsp_tag_q;
  assign grant_cnt_a = cnt_a_q;
  assign grant_cnt_b = cnt_b_q;

endmodule

`default_nettype wire

// File: tb/tb_shift_arbiter_8.sv
//------------------------------------------------------------------------------
// tb_shift_arbiter_8 : directed stimulus with a reference model and result
// scoreboard for shift_arbiter_8 (rotate expectations follow SHIFT_ARB_ROTATE_EN).
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_shift_arbiter_8;

  typedef struct packed {
    logic [7:0] data;
    logic       src;
    logic [3:0] tag;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a_valid = 1'b0, b_valid = 1'b0;
  logic       a_ready, b_ready;
  logic [7:0] a_data = '0, b_data = '0;
  logic [2:0] a_amt = '0, b_amt = '0;
  logic       a_right = 1'b0, b_right = 1'b0;
  logic       a_rot = 1'b0, b_rot = 1'b0;
  logic [3:0] a_tag = '0, b_tag = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [7:0] rsp_data;
  logic       rsp_src;
  logic [3:0] rsp_tag;
  logic [15:0] grant_cnt_a, grant_cnt_b;

  int n_checks = 0;
  int n_errors = 0;

  exp_t        sb_q[$];
  logic        m_full = 1'b0;
  logic        m_ptr = 1'b0;
  logic [15:0] m_cnt_a = '0, m_cnt_b = '0;

  shift_arbiter_8 #(.SHIFT_ARB_TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_amt(a_amt),
    .a_right(a_right), .a_rot(a_rot), .a_tag(a_tag),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data), .b_amt(b_amt),
    .b_right(b_right), .b_rot(b_rot), .b_tag(b_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_src(rsp_src), .rsp_tag(rsp_tag),
    .grant_cnt_a(grant_cnt_a), .grant_cnt_b(grant_cnt_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Bit-by-bit reference: each output bit picks its source bit or fills.
  function automatic logic [7:0] model_shift(input logic [7:0] d, input logic [2:0] amt,
                                             input logic right, input logic rot);
    logic [7:0] r;
    logic       rot_en;
    int         s;
`ifdef SHIFT_ARB_ROTATE_EN
    rot_en = rot;
`else
    rot_en = rot & 1'b0;
`endif
    for (int i = 0; i < 8; i++) begin
      s = right ? (i + int'(amt)) : (i - int'(amt));
      if (s >= 0 && s < 8) r[i] = d[s];
      else if (rot_en)     r[i] = d[(s + 8) % 8];
      else                 r[i] = 1'b0;
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge rst_n) begin
    sb_q.delete();
    m_full  = 1'b0;
    m_ptr   = 1'b0;
    m_cnt_a = '0;
    m_cnt_b = '0;
  end

  // Cycle monitor: predicts readies, checks held result, then advances the model.
  always @(negedge clk) begin
    logic can, ea, eb;
    exp_t e;
    if (!rst_n) begin
      chk("rst_a_ready", a_ready, 0);
      chk("rst_b_ready", b_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_rsp_src", rsp_src, 0);
      chk("rst_rsp_tag", rsp_tag, 0);
      chk("rst_cnt_a", grant_cnt_a, 0);
      chk("rst_cnt_b", grant_cnt_b, 0);
    end else begin
      can = !m_full || rsp_ready;
      ea  = can && a_valid && (!b_valid || m_ptr == 1'b0);
      eb  = can && b_valid && (!a_valid || m_ptr == 1'b1);
      chk("a_ready", a_ready, ea);
      chk("b_ready", b_ready, eb);
      chk("rsp_valid", rsp_valid, m_full);
      chk("cnt_a", grant_cnt_a, m_cnt_a);
      chk("cnt_b", grant_cnt_b, m_cnt_b);
      if (m_full && sb_q.size() > 0) begin
        chk("sb_data", rsp_data, sb_q[0].data);
        chk("sb_src", rsp_src, sb_q[0].src);
        chk("sb_tag", rsp_tag, sb_q[0].tag);
        if (rsp_ready) begin
          void'(sb_q.pop_front());
          m_full = 1'b0;
        end
      end
      if (ea) begin
        e.data = model_shift(a_data, a_amt, a_right, a_rot);
        e.src  = 1'b0;
        e.tag  = a_tag;
        sb_q.push_back(e);
        m_full  = 1'b1;
        m_ptr   = 1'b1;
        m_cnt_a = m_cnt_a + 16'd1;
      end else if (eb) begin
        e.data = model_shift(b_data, b_amt, b_right, b_rot);
        e.src  = 1'b1;
        e.tag  = b_tag;
        sb_q.push_back(e);
        m_full  = 1'b1;
        m_ptr   = 1'b0;
        m_cnt_b = m_cnt_b + 16'd1;
      end
    end
  end

  initial begin
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Single-requester shifts, one-cycle latency
    a_valid = 1'b1; a_data = 8'hB5; a_amt = 3'd3; a_right = 1'b1; a_tag = 4'h5;
    step();
    a_right = 1'b0; a_tag = 4'h6;
    chk("shr_valid", rsp_valid, 1);
    chk("shr_data", rsp_data, 8'h16);
    chk("shr_src", rsp_src, 0);
    chk("shr_tag", rsp_tag, 4'h5);
    step();
    a_valid = 1'b0;
    chk("shl_data", rsp_data, 8'hA8);
    chk("shl_tag", rsp_tag, 4'h6);
    step();

    // Fresh reset so the pointer starts at A, then continuous contention
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    a_valid = 1'b1; a_data = 8'h3C; a_amt = 3'd2; a_right = 1'b0; a_tag = 4'h1;
    b_valid = 1'b1; b_data = 8'hF0; b_amt = 3'd4; b_right = 1'b1; b_tag = 4'h2;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rr_src", rsp_src, i % 2);
      chk("rr_data", rsp_data, (i % 2 == 0) ? 8'hF0 : 8'h0F);
    end
    chk("rr_cnt_a", grant_cnt_a, 2);
    chk("rr_cnt_b", grant_cnt_b, 2);

    // Backpressure while FULL, then simultaneous drain and accept
    rsp_ready = 1'b0;
    #1;
    repeat (5) begin
      chk("bp_a_ready", a_ready, 0);
      chk("bp_b_ready", b_ready, 0);
      chk("bp_valid", rsp_valid, 1);
      chk("bp_src", rsp_src, 1);
      step();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_a_ready", a_ready, 1);
    step();
    chk("bp_refill_valid", rsp_valid, 1);
    chk("bp_refill_src", rsp_src, 0);
    chk("bp_refill_data", rsp_data, model_shift(8'h3C, 3'd2, 1'b0, 1'b0));
    a_valid = 1'b0; b_valid = 1'b0;
    step();

    // Rotate request: rotates only when the feature is built in
    a_valid = 1'b1; a_data = 8'h81; a_amt = 3'd1; a_right = 1'b1; a_rot = 1'b1; a_tag = 4'h9;
    step();
    a_valid = 1'b0; a_rot = 1'b0;
`ifdef SHIFT_ARB_ROTATE_EN
    chk("rot_data", rsp_data, 8'hC0);
`else
    chk("rot_data", rsp_data, 8'h40);
`endif
    step();

    // Reset while holding a result
    rsp_ready = 1'b0;
    a_valid = 1'b1; a_data = 8'h55; a_amt = 3'd1; a_right = 1'b0;
    step();
    chk("pre_rst_valid", rsp_valid, 1);
    b_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", rsp_valid, 0);
    chk("async_rst_data", rsp_data, 0);
    chk("async_rst_cnt_a", grant_cnt_a, 0);
    chk("async_rst_cnt_b", grant_cnt_b, 0);
    chk("async_rst_a_ready", a_ready, 0);
    chk("async_rst_b_ready", b_ready, 0);
    rsp_ready = 1'b1;
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_grant", rsp_src, 0);
    a_valid = 1'b0;
    step();
    chk("post_rst_b_grant", rsp_src, 1);

    // Counter wrap: 65536 A accepts since reset in total
    b_valid = 1'b0; a_valid = 1'b1;
    repeat (65535) begin
      a_data = 8'($urandom);
      a_amt  = 3'($urandom);
      a_right = 1'($urandom);
      step();
    end
    a_valid = 1'b0;
    chk("wrap_cnt_a", grant_cnt_a, 16'h0000);
    chk("wrap_cnt_b", grant_cnt_b, 16'h0001);
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
